// File: rtl/btn_autorepeat_counter_pkg.sv
// Shared types and digit limits for the up/down auto-repeat counter.
// Pure declarations: no latency, no backpressure.
package btn_counter_pkg;

    typedef enum logic [2:0] {IDLE, PRESS, HOLD, REPEAT, BOTH} fsm_t;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_MAX_HEX = 4'hF;
    localparam digit_t DIGIT_MAX_DEC = 4'd9;

    function automatic digit_t digit_max(input bit is_dec);
        return is_dec ? DIGIT_MAX_DEC : DIGIT_MAX_HEX;
    endfunction

endpackage

// File: rtl/btn_autorepeat_counter_if.sv
// Button inputs and display outputs of the auto-repeat counter.
// Plain level/pulse signals: no handshake, no backpressure.
interface btn_autorepeat_counter_if #(
    parameter int NUM_SEGMENTS = 4
);
    logic                         btn_up;
    logic                         btn_dn;
    logic                         clear;
    logic [NUM_SEGMENTS-1:0][3:0] encoded;
    logic [NUM_SEGMENTS-1:0]      digit_point;
    logic                         wrap;
    logic                         step;

    modport master (
        output btn_up, btn_dn, clear,
        input  encoded, digit_point, wrap, step
    );

    modport slave (
        input  btn_up, btn_dn, clear,
        output encoded, digit_point, wrap, step
    );
endinterface

// File: rtl/btn_autorepeat_counter_digit_step.sv
// One digit of the ripple incrementer/decrementer; HEX or BCD per MODE.
// Combinational, zero latency; no backpressure.
module digit_step
    import btn_counter_pkg::*;
#(
    parameter string MODE = "HEX"
) (
    input  digit_t digit,
    input  logic   up,
    input  logic   carry_in,
    output digit_t next_digit,
    output logic   carry_out
);
    localparam digit_t MAX = digit_max(MODE == "DEC");

    always_comb begin
        next_digit = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (up) begin
                if (digit == MAX) begin
                    next_digit = '0;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    next_digit = MAX;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/btn_autorepeat_counter.sv
// Debounced up/down levels -> N-digit HEX/BCD count with hold-to-repeat.
// Count updates 2 cycles after a lone press; no backpressure (display sink).
module btn_autorepeat_counter
    import btn_counter_pkg::*;
#(
    parameter string MODE         = "HEX",
    parameter int    NUM_SEGMENTS = 4,
    parameter int    CLK_PER      = 10,
    parameter int    HOLD_MS      = 500,
    parameter int    REPEAT_MS    = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    btn_autorepeat_counter_if.slave  bus
);
    localparam int MS_CYCLES = 1_000_000 / CLK_PER;
    localparam int PW        = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int TMAX      = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int TW        = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRE_LAST    = PW'(MS_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_MS - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_MS - 1);

    logic [PW-1:0] pre;
    logic          ms_tick;
    logic [TW-1:0] ms_cnt, ms_cnt_nxt;
    fsm_t          state, state_nxt;
    logic          dir, dir_nxt;
    logic          do_step;
    logic          both, held;
    logic          step_q, wrap_q;

    logic [NUM_SEGMENTS-1:0][3:0] cnt, cnt_nxt;
    logic [NUM_SEGMENTS:0]        carry;

    assign ms_tick = (pre == PRE_LAST);
    assign both    = bus.btn_up & bus.btn_dn;
    assign held    = dir ? bus.btn_up : bus.btn_dn;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
        end else begin
            pre <= ms_tick ? '0 : pre + PW'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir;
        ms_cnt_nxt = ms_cnt;
        do_step    = 1'b0;
        case (state)
            IDLE: begin
                if (both) begin
                    state_nxt = BOTH;
                end else if (bus.btn_up ^ bus.btn_dn) begin
                    state_nxt = PRESS;
                    dir_nxt   = bus.btn_up;
                end
            end
            PRESS: begin
                if (both) begin
                    state_nxt = BOTH;
                end else begin
                    do_step    = 1'b1;
                    ms_cnt_nxt = '0;
                    state_nxt  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (both) begin
                    state_nxt = BOTH;
                end else if (!held) begin
                    state_nxt = IDLE;
                end else if (ms_tick) begin
                    // HOLD waits for the initial delay, REPEAT for the repeat interval
                    if (ms_cnt == ((state == HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                        do_step    = 1'b1;
                        ms_cnt_nxt = '0;
                        state_nxt  = REPEAT;
                    end else begin
                        ms_cnt_nxt = ms_cnt + TW'(1);
                    end
                end
            end
            BOTH: begin
                if (!bus.btn_up && !bus.btn_dn) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // carry[i] doubles as "apply the step to digit i"
    assign carry[0] = do_step;

    for (genvar i = 0; i < NUM_SEGMENTS; i++) begin : g_digit
        digit_step #(.MODE(MODE)) u_digit (
            .digit      (cnt[i]),
            .up         (dir),
            .carry_in   (carry[i]),
            .next_digit (cnt_nxt[i]),
            .carry_out  (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            dir    <= 1'b0;
            ms_cnt <= '0;
            cnt    <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            dir    <= dir_nxt;
            ms_cnt <= ms_cnt_nxt;
            if (bus.clear) begin
                cnt    <= '0;
                step_q <= 1'b0;
                wrap_q <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                step_q <= do_step;
                wrap_q <= carry[NUM_SEGMENTS];
            end
        end
    end

    assign bus.encoded     = cnt;
    assign bus.step        = step_q;
    assign bus.wrap        = wrap_q;
    assign bus.digit_point = NUM_SEGMENTS'(state == REPEAT);

endmodule

// File: tb/tb_btn_autorepeat_counter.sv
// Two counters (DEC at 1 cycle/ms, HEX with a 4-cycle ms prescaler) driven
// by the same buttons and compared every cycle against an integer model.
module tb_btn_autorepeat_counter;

    logic clk = 1'b0;
    logic reset;
    logic up, dn, clr;

    always #5 clk = ~clk;

    btn_autorepeat_counter_if #(.NUM_SEGMENTS(4)) ifa ();
    btn_autorepeat_counter_if #(.NUM_SEGMENTS(4)) ifb ();

    assign ifa.btn_up = up;
    assign ifa.btn_dn = dn;
    assign ifa.clear  = clr;
    assign ifb.btn_up = up;
    assign ifb.btn_dn = dn;
    assign ifb.clear  = clr;

    btn_autorepeat_counter #(
        .MODE("DEC"), .NUM_SEGMENTS(4), .CLK_PER(1_000_000), .HOLD_MS(5), .REPEAT_MS(2)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    btn_autorepeat_counter #(
        .MODE("HEX"), .NUM_SEGMENTS(4), .CLK_PER(250_000), .HOLD_MS(3), .REPEAT_MS(2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int vectors     = 0;
    int miscompares = 0;

    // reference model: one entry per counter
    localparam int M_IDLE = 0, M_PRESS = 1, M_HOLD = 2, M_REPEAT = 3, M_BOTH = 4;
    int ms_per[2] = '{1, 4};
    int hold_ms[2] = '{5, 3};
    int rep_ms[2] = '{2, 2};
    bit is_dec[2] = '{1'b1, 1'b0};
    int modulus[2] = '{10000, 65536};

    int m_mode[2], m_pre[2], m_el[2], m_cnt[2];
    bit m_dir[2], m_step[2], m_wrap[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_enc(input int k);
        logic [15:0] r;
        int v;
        v = m_cnt[k];
        r = '0;
        if (is_dec[k]) begin
            for (int i = 0; i < 4; i++) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end else begin
            r = 16'(v);
        end
        return r;
    endfunction

    // advance model k by one clock edge using the inputs presented to it
    task automatic model(input int k);
        bit tick, st, wr, hold_btn;
        int limit;
        st = 1'b0;
        wr = 1'b0;
        if (reset) begin
            m_mode[k] = M_IDLE; m_pre[k] = 0; m_el[k] = 0; m_cnt[k] = 0;
            m_dir[k] = 1'b0; m_step[k] = 1'b0; m_wrap[k] = 1'b0;
            return;
        end
        tick = (m_pre[k] == ms_per[k] - 1);
        m_pre[k] = tick ? 0 : m_pre[k] + 1;
        hold_btn = m_dir[k] ? up : dn;
        limit = (m_mode[k] == M_HOLD) ? hold_ms[k] : rep_ms[k];
        if (m_mode[k] != M_BOTH && up && dn) begin
            m_mode[k] = M_BOTH;
        end else begin
            case (m_mode[k])
                M_IDLE: if (up != dn) begin m_mode[k] = M_PRESS; m_dir[k] = up; end
                M_PRESS: begin st = 1'b1; m_el[k] = 0; m_mode[k] = M_HOLD; end
                M_BOTH: if (!up && !dn) m_mode[k] = M_IDLE;
                default: begin
                    if (!hold_btn) m_mode[k] = M_IDLE;
                    else if (tick) begin
                        m_el[k]++;
                        if (m_el[k] == limit) begin
                            st = 1'b1; m_el[k] = 0; m_mode[k] = M_REPEAT;
                        end
                    end
                end
            endcase
        end
        if (clr) begin
            m_cnt[k] = 0; st = 1'b0;
        end else if (st) begin
            if (m_dir[k]) begin
                wr = (m_cnt[k] == modulus[k] - 1);
                m_cnt[k] = (m_cnt[k] + 1) % modulus[k];
            end else begin
                wr = (m_cnt[k] == 0);
                m_cnt[k] = (m_cnt[k] + modulus[k] - 1) % modulus[k];
            end
        end
        m_step[k] = st;
        m_wrap[k] = wr;
    endtask

    task automatic cycle();
        model(0);
        model(1);
        @(posedge clk);
        #1;
        chk("A.encoded", 32'(ifa.encoded), 32'(exp_enc(0)));
        chk("A.step", 32'(ifa.step), 32'(m_step[0]));
        chk("A.wrap", 32'(ifa.wrap), 32'(m_wrap[0]));
        chk("A.digit_point", 32'(ifa.digit_point), 32'(m_mode[0] == M_REPEAT));
        chk("B.encoded", 32'(ifb.encoded), 32'(exp_enc(1)));
        chk("B.step", 32'(ifb.step), 32'(m_step[1]));
        chk("B.wrap", 32'(ifb.wrap), 32'(m_wrap[1]));
        chk("B.digit_point", 32'(ifb.digit_point), 32'(m_mode[1] == M_REPEAT));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        up = 1'b0; dn = 1'b0; clr = 1'b0; reset = 1'b1;
        run(2);
        reset = 1'b0;

        // 12 short presses
        for (int i = 0; i < 12; i++) begin
            up = 1'b1; run(3);
            up = 1'b0; run(3);
        end
        chk("A.dec12", 32'(ifa.encoded), 32'h0012);
        chk("B.hex12", 32'(ifb.encoded), 32'h000C);

        // hold-to-repeat
        clr = 1'b1; run(1); clr = 1'b0;
        up = 1'b1; run(14);
        chk("A.repeat_dp", 32'(ifa.digit_point), 32'h1);
        up = 1'b0; run(3);
        chk("A.repeat5", 32'(ifa.encoded), 32'h0005);

        // both buttons suppress steps
        clr = 1'b1; run(1); clr = 1'b0;
        up = 1'b1; run(4);
        dn = 1'b1; run(6);
        up = 1'b0; run(4);
        dn = 1'b0; run(2);
        dn = 1'b1; run(3);
        dn = 1'b0; run(3);
        chk("A.both", 32'(ifa.encoded), 32'h0000);

        // clear collides with the first step
        up = 1'b1; run(1);
        clr = 1'b1; run(1); clr = 1'b0;
        chk("A.clr_step", 32'(ifa.step), 32'h0);
        up = 1'b0; run(3);

        // roll-under and roll-over
        dn = 1'b1; run(3); dn = 1'b0; run(3);
        chk("A.under", 32'(ifa.encoded), 32'h9999);
        chk("B.under", 32'(ifb.encoded), 32'hFFFF);
        up = 1'b1; run(3); up = 1'b0; run(3);
        chk("A.over", 32'(ifa.encoded), 32'h0000);
        chk("B.over", 32'(ifb.encoded), 32'h0000);

        // reset while repeating, button still held afterwards
        up = 1'b1; run(20);
        reset = 1'b1; run(1); reset = 1'b0;
        run(3);
        chk("A.after_reset", 32'(ifa.encoded), 32'h0001);
        up = 1'b0; run(3);

        // random levels, clears and resets
        for (int s = 0; s < 150; s++) begin
            int len;
            up = 1'($urandom_range(0, 1));
            dn = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++) begin
                clr = ($urandom_range(0, 31) == 0);
                reset = ($urandom_range(0, 199) == 0);
                cycle();
            end
        end
        clr = 1'b0; reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
